// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundle of the pipeline-side and RAM-side buses of mem_arbiter.
//   slave modport  : arbiter view (requests/ram_rdata in, responses/RAM controls out)
//   master modport : pipeline + RAM view (the opposite directions)
//   Pipeline fetch : if_req, if_addr -> if_rdata, if_valid
//   Pipeline data  : ctrl_MEM {MEM_RD_n, MEM_WR_n, w_h}, mem_addr, mem_wdata -> mem_rdata, mem_valid
//   Freeze         : stall_IF, stall_MEM
//   RAM            : ram_en, ram_we, ram_wmask, ram_addr, ram_wdata <- ram_rdata
interface mem_arbiter_if #(
    parameter int ADDR_W = 30
);
    logic              if_req;
    logic [31:0]       if_addr;
    logic [31:0]       if_rdata;
    logic              if_valid;
    logic [2:0]        ctrl_MEM;
    logic [31:0]       mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_valid;
    logic              stall_IF;
    logic              stall_MEM;
    logic              ram_en;
    logic              ram_we;
    logic [3:0]        ram_wmask;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;

    modport slave (
        input  if_req, if_addr, ctrl_MEM, mem_addr, mem_wdata, ram_rdata,
        output if_rdata, if_valid, mem_rdata, mem_valid, stall_IF, stall_MEM,
               ram_en, ram_we, ram_wmask, ram_addr, ram_wdata
    );

    modport master (
        output if_req, if_addr, ctrl_MEM, mem_addr, mem_wdata, ram_rdata,
        input  if_rdata, if_valid, mem_rdata, mem_valid, stall_IF, stall_MEM,
               ram_en, ram_we, ram_wmask, ram_addr, ram_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port RAM arbiter/sequencer between instruction fetch and
// the MEM stage. The MEM stage always wins. Each access occupies the RAM for
// MEM_LAT+1 cycles (launch, MEM_LAT-1 wait cycles, completion).
//   clk, reset : clock and synchronous active-high reset
//   bus        : mem_arbiter_if.slave (pipeline request/response, stalls, RAM port)
//   Optional macro ARB_PERF_EN adds perf_stall_if / perf_stall_mem, saturating
//   32-bit counts of cycles each stall output was high.
module mem_arbiter #(
    parameter int MEM_LAT = 2,
    parameter int ADDR_W  = 30
) (
    input  logic clk,
    input  logic reset,
    mem_arbiter_if.slave bus
`ifdef ARB_PERF_EN
    ,
    output logic [31:0] perf_stall_if,
    output logic [31:0] perf_stall_mem
`endif
);
    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

    typedef enum logic [1:0] {IDLE, DATA, INST} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             acc_wr, acc_wr_nxt;
    logic [31:0]      mem_hold, if_hold;
    logic             dreq, data_wr;
    logic             launch, launch_data, done;

    // {MEM_RD, MEM_WR} are active-low; both low counts as a write.
    assign dreq    = !bus.ctrl_MEM[2] || !bus.ctrl_MEM[1];
    assign data_wr = !bus.ctrl_MEM[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            acc_wr   <= 1'b0;
            mem_hold <= '0;
            if_hold  <= '0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            acc_wr <= acc_wr_nxt;
            if (bus.mem_valid && !acc_wr) mem_hold <= bus.ram_rdata;
            if (bus.if_valid)             if_hold  <= bus.ram_rdata;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        acc_wr_nxt  = acc_wr;
        launch      = 1'b0;
        launch_data = 1'b0;
        done        = 1'b0;
        case (state)
            IDLE: begin
                if (dreq) begin
                    launch      = 1'b1;
                    launch_data = 1'b1;
                    acc_wr_nxt  = data_wr;
                    cnt_nxt     = CNT_LOAD;
                    state_nxt   = DATA;
                end else if (bus.if_req) begin
                    launch     = 1'b1;
                    acc_wr_nxt = 1'b0;
                    cnt_nxt    = CNT_LOAD;
                    state_nxt  = INST;
                end
            end
            DATA, INST: begin
                if (cnt == '0) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // RAM launch is combinational from IDLE; everything is forced low while reset is high.
    always_comb begin
        bus.ram_en    = 1'b0;
        bus.ram_we    = 1'b0;
        bus.ram_wmask = 4'b0000;
        bus.ram_addr  = '0;
        bus.ram_wdata = '0;
        if (!reset && launch) begin
            bus.ram_en = 1'b1;
            if (launch_data) begin
                bus.ram_addr = bus.mem_addr[ADDR_W+1:2];
                if (data_wr) begin
                    bus.ram_we = 1'b1;
                    if (bus.ctrl_MEM[0]) begin
                        bus.ram_wmask = 4'b1111;
                        bus.ram_wdata = bus.mem_wdata;
                    end else begin
                        bus.ram_wmask = bus.mem_addr[1] ? 4'b1100 : 4'b0011;
                        bus.ram_wdata = {bus.mem_wdata[15:0], bus.mem_wdata[15:0]};
                    end
                end
            end else begin
                bus.ram_addr = bus.if_addr[ADDR_W+1:2];
            end
        end
    end

    assign bus.mem_valid = !reset && done && (state == DATA);
    assign bus.if_valid  = !reset && done && (state == INST);
    // Read data flows through in the completion cycle; a write's RAM data is discarded.
    assign bus.mem_rdata = (bus.mem_valid && !acc_wr) ? bus.ram_rdata : mem_hold;
    assign bus.if_rdata  = bus.if_valid ? bus.ram_rdata : if_hold;
    assign bus.stall_MEM = !reset && dreq && !bus.mem_valid;
    assign bus.stall_IF  = bus.stall_MEM || (!reset && bus.if_req && !bus.if_valid);

    // Address bits outside the word index are intentionally ignored.
    logic unused_addr;
    assign unused_addr = ^{bus.if_addr, bus.mem_addr};

`ifdef ARB_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_stall_if  <= '0;
            perf_stall_mem <= '0;
        end else begin
            if (bus.stall_IF && (perf_stall_if != 32'hFFFF_FFFF))
                perf_stall_if <= perf_stall_if + 32'd1;
            if (bus.stall_MEM && (perf_stall_mem != 32'hFFFF_FFFF))
                perf_stall_mem <= perf_stall_mem + 32'd1;
        end
    end
`endif
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Single-port main-memory arbiter/sequencer between instruction fetch (IF) and data access (MEM stage: lw, sw, sh).
- Sits between the pipeline and the shared RAM. Serialises accesses, counts the fixed RAM latency, builds byte masks for sh/sw, and drives the pipeline freeze signals.
- MEM stage always wins, because it holds the older instruction.

Parameters:
- MEM_LAT, 2, RAM read/write latency in cycles (≥1).
- ADDR_W, 30, word-address width driven to RAM.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- if_req  in  1  fetch request; held until if_valid
- if_addr  in  32  fetch byte address
- if_rdata  out  32  fetched instruction
- if_valid  out  1  fetch complete (1-cycle pulse)
- ctrl_MEM  in  3  {MEM_RD, MEM_WR, w_h}; MEM_RD/MEM_WR active-low; w_h 1=word, 0=halfword
- mem_addr  in  32  data byte address
- mem_wdata  in  32  store data
- mem_rdata  out  32  load data
- mem_valid  out  1  data access complete (1-cycle pulse)
- stall_IF  out  1  freeze PC and IF/ID
- stall_MEM  out  1  freeze entire pipe
- ram_en  out  1  RAM access launch (1 cycle)
- ram_we  out  1  RAM write
- ram_wmask  out  4  byte-lane write enables
- ram_addr  out  ADDR_W  word address = addr[ADDR_W+1:2]
- ram_wdata  out  32  RAM write data
- ram_rdata  in  32  valid exactly MEM_LAT cycles after the ram_en cycle

Behaviour:
- FSM states: IDLE, DATA, INST. A down-counter cnt is sized for MEM_LAT.
- Data request (dreq) = MEM_RD==0 or MEM_WR==0.
- Both MEM_RD and MEM_WR low is treated as a write; read data is discarded.
- IDLE with dreq:
  - ram_en=1 in the same cycle (combinational launch).
  - ram_we = !MEM_WR.
  - cnt loaded MEM_LAT-1; next state DATA.
- IDLE with if_req and no dreq: same launch with ram_we=0; next state INST.
- Both dreq and if_req in IDLE: data launches; fetch waits.
- DATA/INST:
  - ram_en=0.
  - cnt decrements each cycle.
  - cnt==0 is the completion cycle. It pulses mem_valid or if_valid and drives mem_rdata or if_rdata from ram_rdata, which is also captured into a hold register.
  - Next state IDLE.
- Timing:
  - Launch at cycle T, completion at T+MEM_LAT.
  - Next launch no earlier than T+MEM_LAT+1, so throughput is one access per MEM_LAT+1 cycles.
- After completion, mem_rdata/if_rdata hold the last captured value.
- Write mask:
  - Word: 4'b1111, ram_wdata = mem_wdata.
  - Halfword, addr[1]==0: 4'b0011.
  - Halfword, addr[1]==1: 4'b1100.
  - Halfword ram_wdata = {mem_wdata[15:0], mem_wdata[15:0]}.
  - Reads: ram_wmask = 4'b0000.
- Address bits [1:0] are ignored for words. Bit 0 is ignored for halfwords.
- stall_MEM = dreq && !mem_valid.
- stall_IF = stall_MEM || (if_req && !if_valid).
- In the completion cycle the relevant stall is low so the pipe advances.
- A requester dropping its request mid-access: the access still completes and valid still pulses.
- Reset:
  - State IDLE, cnt 0.
  - ram_en, ram_we, ram_wmask, both valids and both rdata registers are 0.
  - The stalls read 0 while reset is high.
  - An access in flight is abandoned; ram_rdata arriving later is ignored.
  - Requests are honoured starting the first cycle after reset deasserts.

Optional Feature:
- ARB_PERF_EN defined:
  - Adds output ports perf_stall_if[31:0] and perf_stall_mem[31:0].
  - Each increments on every cycle its stall output is 1.
  - Each saturates at 32'hFFFF_FFFF.
  - Both clear on reset.
- ARB_PERF_EN undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Load word (MEM_LAT=2): ctrl_MEM=3'b011, mem_addr=32'h0000_0010 at T, RAM word 4 = 32'hDEAD_BEEF.
  - Expect ram_en=1, ram_addr=4, ram_we=0 at T.
  - Expect mem_valid=1, mem_rdata=32'hDEAD_BEEF at T+2.
  - Expect stall_MEM=1 during T..T+1 and 0 at T+2.
- sh upper half: ctrl_MEM=3'b100, mem_addr=32'h0000_0022, mem_wdata=32'h0000_1234.
  - Expect ram_we=1, ram_wmask=4'b1100, ram_wdata=32'h1234_1234, ram_addr=8.
- sw: ctrl_MEM=3'b101, mem_addr=32'h0000_0007.
  - Expect ram_wmask=4'b1111, ram_addr=1.
- Collision: if_req=1 (if_addr=0) and an lw, both in the same IDLE cycle T.
  - Expect the data access to launch at T.
  - Expect the fetch to launch at T+3 and if_valid at T+5.
  - Expect stall_IF=1 for T..T+4.
- Reset mid-access: assert reset at T+1 of an lw.
  - Expect all outputs 0 and no mem_valid afterwards.
  - After reset deasserts, a new fetch completes normally with correct if_rdata.
- MEM_LAT=1: back-to-back fetches.
  - Expect ram_en at T and T+2, if_valid at T+1 and T+3.
  - With ARB_PERF_EN defined, expect perf_stall_if to equal the number of cycles stall_IF was high.
